// File: rtl/addressed_router_arbiter_hub.sv
// -----------------------------------------------------------------------------
// addressed_router_arbiter_hub
//
// Purpose:
//   Hub between one upstream val/rdy stream and N_PORTS downstream endpoints.
//   Downstream: the address prefix in the MSBs of recv_msg selects a port and
//   the payload is queued in that port's output FIFO. Packets addressed to a
//   disabled port are accepted and discarded, and they are counted in a
//   saturating drop counter.
//   Upstream: the port return streams are round-robin arbitrated into a
//   1-entry output register. The winning port's address is prepended to its
//   payload.
//
// Ports:
//   clk, reset      clock (rising edge) and synchronous active-high reset
//   recv_msg/val/rdy  upstream request stream {addr, payload}
//   send_msg/val/rdy  upstream return stream {src_addr, payload}
//   port_send_*     per-port downstream streams, packed [i*BIT_WIDTH +: BIT_WIDTH]
//   port_recv_*     per-port return streams, same packing; rdy is one-hot or zero
//   port_enable     1 = port routable, 0 = packets to it are dropped
//   drop_count      saturating 16-bit count of dropped packets
// -----------------------------------------------------------------------------
module addressed_router_arbiter_hub #(
    parameter int BIT_WIDTH  = 32,
    parameter int N_PORTS    = 16,
    parameter int FIFO_DEPTH = 2,
    localparam int ADDR_BITS = $clog2(N_PORTS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ADDR_BITS+BIT_WIDTH-1:0] recv_msg,
    input  logic                           recv_val,
    output logic                           recv_rdy,
    output logic [ADDR_BITS+BIT_WIDTH-1:0] send_msg,
    output logic                           send_val,
    input  logic                           send_rdy,
    output logic [N_PORTS*BIT_WIDTH-1:0]   port_send_msg,
    output logic [N_PORTS-1:0]             port_send_val,
    input  logic [N_PORTS-1:0]             port_send_rdy,
    input  logic [N_PORTS*BIT_WIDTH-1:0]   port_recv_msg,
    input  logic [N_PORTS-1:0]             port_recv_val,
    output logic [N_PORTS-1:0]             port_recv_rdy,
    input  logic [N_PORTS-1:0]             port_enable,
    output logic [15:0]                    drop_count
);

    localparam int MSG_W = ADDR_BITS + BIT_WIDTH;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } up_state_t;

    // Advance a FIFO pointer, wrapping at FIFO_DEPTH (depth need not be a power of 2).
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            n = '0;
        end else begin
            n = p + 1'b1;
        end
        return n;
    endfunction

    // ---------------------------------------------------------------- storage
    logic [BIT_WIDTH-1:0] fifo_mem_r [N_PORTS][FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r   [N_PORTS];
    logic [PTR_W-1:0]     rd_ptr_r   [N_PORTS];
    logic [CNT_W-1:0]     count_r    [N_PORTS];
    logic [15:0]          drop_count_r;

    up_state_t            state_r;
    logic                 send_val_r;
    logic [MSG_W-1:0]     send_msg_r;
    logic [ADDR_BITS-1:0] rr_ptr_r;

    // ---------------------------------------------------------- combinational
    logic [ADDR_BITS-1:0] addr_s;
    logic [BIT_WIDTH-1:0] payload_s;
    logic [N_PORTS-1:0]   full_s;
    logic [N_PORTS-1:0]   nonempty_s;
    logic [N_PORTS-1:0]   enq_s;
    logic [N_PORTS-1:0]   deq_s;
    logic                 accept_s;
    logic                 drop_hit_s;

    logic                 found_s;
    logic [ADDR_BITS-1:0] grant_s;
    logic                 can_grant_s;
    logic                 grant_fire_s;
    logic [BIT_WIDTH-1:0] grant_msg_s;
    logic [N_PORTS-1:0]   port_recv_rdy_s;

    assign addr_s    = recv_msg[MSG_W-1 -: ADDR_BITS];
    assign payload_s = recv_msg[BIT_WIDTH-1:0];

    // A disabled port always accepts so the stream never stalls on a dead address.
    assign recv_rdy   = port_enable[addr_s] ? ~full_s[addr_s] : 1'b1;
    assign accept_s   = recv_val & recv_rdy;
    assign drop_hit_s = accept_s & ~port_enable[addr_s];

    // Per-port FIFO occupancy flags and enqueue/dequeue strobes.
    always_comb begin
        full_s     = '0;
        nonempty_s = '0;
        enq_s      = '0;
        deq_s      = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            full_s[i]     = (count_r[i] == CNT_W'(FIFO_DEPTH));
            nonempty_s[i] = (count_r[i] != '0);
            enq_s[i]      = accept_s & port_enable[i] & (addr_s == ADDR_BITS'(i));
            deq_s[i]      = nonempty_s[i] & port_send_rdy[i];
        end
    end

    // Round-robin search: first valid port at or above rr_ptr_r, wrapping.
    always_comb begin
        found_s = 1'b0;
        grant_s = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            grant_s = (!found_s && port_recv_val[rr_ptr_r + ADDR_BITS'(k)])
                      ? (rr_ptr_r + ADDR_BITS'(k)) : grant_s;
            found_s = found_s | port_recv_val[rr_ptr_r + ADDR_BITS'(k)];
        end
    end

    // Grant qualification, one-hot return ready and payload mux of the winner.
    always_comb begin
        can_grant_s     = (state_r == ST_EMPTY) || send_rdy;
        grant_fire_s    = can_grant_s && found_s;
        port_recv_rdy_s = grant_fire_s ? ({{(N_PORTS-1){1'b0}}, 1'b1} << grant_s) : '0;
        grant_msg_s     = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            grant_msg_s = (grant_s == ADDR_BITS'(i))
                          ? port_recv_msg[i*BIT_WIDTH +: BIT_WIDTH] : grant_msg_s;
        end
    end

    // ------------------------------------------------------------- sequential
    // FIFO payload storage; contents are don't-care while a slot is empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_PORTS; i++) begin
            if (enq_s[i]) begin
                fifo_mem_r[i][wr_ptr_r[i]] <= payload_s;
            end else begin
                fifo_mem_r[i][wr_ptr_r[i]] <= fifo_mem_r[i][wr_ptr_r[i]];
            end
        end
    end

    // FIFO pointers and occupancy; a dequeue on a full FIFO frees the slot next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_PORTS; i++) begin
                wr_ptr_r[i] <= '0;
                rd_ptr_r[i] <= '0;
                count_r[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                wr_ptr_r[i] <= enq_s[i] ? next_ptr(wr_ptr_r[i]) : wr_ptr_r[i];
                rd_ptr_r[i] <= deq_s[i] ? next_ptr(rd_ptr_r[i]) : rd_ptr_r[i];
                count_r[i]  <= count_r[i] + CNT_W'(enq_s[i]) - CNT_W'(deq_s[i]);
            end
        end
    end

    // Saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count_r <= 16'h0000;
        end else if (drop_hit_s && (drop_count_r != 16'hFFFF)) begin
            drop_count_r <= drop_count_r + 16'h0001;
        end else begin
            drop_count_r <= drop_count_r;
        end
    end

    // Upstream output register FSM; a drain and a new grant may share a cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_EMPTY;
            send_val_r <= 1'b0;
            send_msg_r <= '0;
            rr_ptr_r   <= '0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (grant_fire_s) begin
                        state_r    <= ST_FULL;
                        send_val_r <= 1'b1;
                        send_msg_r <= {grant_s, grant_msg_s};
                        rr_ptr_r   <= grant_s + 1'b1;
                    end else begin
                        state_r    <= ST_EMPTY;
                        send_val_r <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (grant_fire_s) begin
                        state_r    <= ST_FULL;
                        send_val_r <= 1'b1;
                        send_msg_r <= {grant_s, grant_msg_s};
                        rr_ptr_r   <= grant_s + 1'b1;
                    end else if (send_rdy) begin
                        state_r    <= ST_EMPTY;
                        send_val_r <= 1'b0;
                    end else begin
                        state_r    <= ST_FULL;
                        send_val_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_EMPTY;
                    send_val_r <= 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port_out
        assign port_send_msg[gi*BIT_WIDTH +: BIT_WIDTH] = fifo_mem_r[gi][rd_ptr_r[gi]];
    end

    assign port_send_val = nonempty_s;
    assign port_recv_rdy = port_recv_rdy_s;
    assign send_val      = send_val_r;
    assign send_msg      = send_msg_r;
    assign drop_count    = drop_count_r;

endmodule
